// File: rtl/sram_scan_host.sv
// rtl/sram_scan_host.sv - parallel command/data to serial scan-chain host for sram_scan_wrapper
// Frames header and write data LSB-first onto scan_in and deserializes read words from scan_out.
module sram_scan_host #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 31,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int RST_CYCLES = 10,
  parameter int READ_LAT   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rdata_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_underrun_o,
  output logic              busy_o,
  output logic              chain_rst_n_o,
  output logic              scan_in_o,
  input  logic              scan_out_i
);

  localparam int HDR_W = 1 + CNT_W + ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CRST  = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]  word_q, word_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [HDR_W-1:0]  sh_q, sh_d;
  logic              scan_in_q, scan_in_d;
  logic              chain_rst_n_q, chain_rst_n_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;
  logic              wdata_ready;
  logic              at_boundary;
  logic [HDR_W-1:0]  hdr;
  logic [LEN_W-1:0]  word_inc;
  logic [DATA_W-1:0] rd_word;

  assign hdr      = {addr_q, CNT_W'(len_q), write_q};
  assign word_inc = word_q + 1'b1;
  assign rd_word  = {scan_out_i, sh_q[DATA_W-1:1]};

  // scan_in_d / chain_rst_n_d describe the pins for the cycle after the coming edge,
  // so the wrapper sees each bit for one full cycle in the state that owns it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    len_d         = len_q;
    addr_d        = addr_q;
    write_d       = write_q;
    sh_d          = sh_q;
    scan_in_d     = 1'b0;
    chain_rst_n_d = 1'b1;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = err_q;
    wdata_ready   = 1'b0;
    at_boundary   = 1'b0;

    case (state_q)
      S_IDLE: begin
        chain_rst_n_d = 1'b0;
        if (cmd_valid_i) begin
          write_d = cmd_write_i;
          len_d   = cmd_len_i;
          addr_d  = cmd_addr_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CRST;
        end
      end
      S_CRST: begin
        if (cnt_q == 6'(RST_CYCLES - 1)) begin
          cnt_d     = '0;
          scan_in_d = hdr[0];
          sh_d      = hdr >> 1;
          state_d   = S_HDR;
        end else begin
          chain_rst_n_d = 1'b0;
          cnt_d         = cnt_q + 6'd1;
        end
      end
      S_HDR: begin
        if (cnt_q != 6'(HDR_W - 1)) begin
          cnt_d     = cnt_q + 6'd1;
          scan_in_d = sh_q[0];
          sh_d      = sh_q >> 1;
        end else begin
          cnt_d  = '0;
          word_d = '0;
          if (len_q == '0)        state_d = S_DONE;
          else if (write_q)       at_boundary = 1'b1;
          else if (READ_LAT == 0) state_d = S_RDATA;
          else                    state_d = S_RWAIT;
        end
      end
      S_WDATA: begin
        if (cnt_q != 6'(DATA_W - 1)) begin
          cnt_d     = cnt_q + 6'd1;
          scan_in_d = sh_q[0];
          sh_d      = sh_q >> 1;
        end else begin
          cnt_d  = '0;
          word_d = word_inc;
          if (word_inc == len_q) state_d = S_DONE;
          else                   at_boundary = 1'b1;
        end
      end
      S_RWAIT: begin
        if (cnt_q == 6'(READ_LAT - 1)) begin
          cnt_d   = '0;
          state_d = S_RDATA;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_RDATA: begin
        sh_d = HDR_W'(rd_word);
        if (cnt_q == 6'(DATA_W - 1)) begin
          cnt_d         = '0;
          rdata_d       = rd_word;
          rdata_valid_d = 1'b1;
          word_d        = word_inc;
          if (word_inc == len_q) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        chain_rst_n_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: begin
        chain_rst_n_d = 1'b0;
        state_d       = S_IDLE;
      end
    endcase

    // Next word is taken in the last cycle of the previous one so its bit 0 follows without a gap.
    if (at_boundary) begin
      if (wdata_valid_i) begin
        wdata_ready = 1'b1;
        scan_in_d   = wdata_i[0];
        sh_d        = HDR_W'(wdata_i >> 1);
        state_d     = S_WDATA;
      end else begin
        err_d         = 1'b1;
        chain_rst_n_d = 1'b0;
        state_d       = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      word_q        <= '0;
      len_q         <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      sh_q          <= '0;
      scan_in_q     <= 1'b0;
      chain_rst_n_q <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      sh_q          <= sh_d;
      scan_in_q     <= scan_in_d;
      chain_rst_n_q <= chain_rst_n_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  assign cmd_ready_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign wdata_ready_o  = wdata_ready;
  assign rdata_valid_o  = rdata_valid_q;
  assign rdata_o        = rdata_q;
  assign err_underrun_o = err_q;
  assign chain_rst_n_o  = chain_rst_n_q;
  assign scan_in_o      = scan_in_q;

endmodule

// File: doc/sram_scan_host.md
Name: sram_scan_host

Overview:
- Parallel-to-scan host controller that drives sram_scan_wrapper's serial port: chain reset, scan_in and scan_out.
- Takes a command (read/write, word count, start address) and write words over valid/ready. Serializes header and data LSB-first into the chain.
- For reads, deserializes scan_out back into 32-bit words.
- Sits between the system bus / loader and the SRAM scan wrapper.

Parameters:
DATA_W, 32, data word width
CNT_W, 31, chain addr_count field width
ADDR_W, 32, chain address field width
LEN_W, 16, cmd_len width
RST_CYCLES, 10, chain reset low cycles before each transaction
READ_LAT, 1, cycles between last header bit sampled and first read bit valid on scan_out

Ports:
clk  in  1  clock; the wrapper runs on the same clk
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_len  in  LEN_W  number of words to transfer
cmd_addr  in  ADDR_W  start address
wdata_valid  in  1  write word offered
wdata_ready  out  1  word accepted this cycle
wdata  in  DATA_W  write word
rdata_valid  out  1  one-cycle pulse, rdata valid; no backpressure
rdata  out  DATA_W  read word
done  out  1  one-cycle pulse at normal completion
err_underrun  out  1  sticky; cleared by next accepted command
busy  out  1  high whenever not IDLE
chain_rst_n  out  1  to wrapper rst_n
scan_in  out  1  to wrapper scan_in
scan_out  in  1  from wrapper scan_out

Behaviour:
- Reset values:
  - cmd_ready=1, chain_rst_n=0, scan_in=0.
  - wdata_ready, rdata_valid, done, err_underrun, busy = 0.
  - rdata=0.
  - FSM=IDLE.
- Registered outputs: scan_in and chain_rst_n are registered. A value driven in cycle k is sampled by the wrapper at the edge ending cycle k.
- IDLE: chain_rst_n=0, scan_in=0.
  - cmd_valid&&cmd_ready latches cmd_write, cmd_len and cmd_addr, clears err_underrun, and enters CRST.
- CRST: chain_rst_n=0 for exactly RST_CYCLES cycles, then HDR with chain_rst_n=1.
- HDR: 64 cycles, one bit each.
  - Bit 0 = cmd_write.
  - Bits 1..31 = cmd_len zero-extended to CNT_W, LSB first.
  - Bits 32..63 = cmd_addr, LSB first.
  - Then:
    - cmd_len==0 → DONE.
    - write → WDATA.
    - read → RWAIT.
- WDATA:
  - At each word boundary (first WDATA cycle and after every 32nd bit):
    - If wdata_valid, assert wdata_ready for that cycle and load the shift register. Bit 0 goes out the same cycle, so words run back-to-back with no gap bits.
    - If !wdata_valid, set err_underrun and go to IDLE without done. chain_rst_n drops the next cycle, aborting the chain.
  - After cmd_len words → DONE.
- RWAIT: scan_in=0 for READ_LAT cycles → RDATA.
- RDATA:
  - Sample scan_out every cycle into bit position 0..31 (LSB first).
  - After the 32nd sample, rdata is updated and rdata_valid pulses in the next cycle.
  - After cmd_len words → DONE. scan_in=0 throughout.
- DONE: one cycle; done=1, chain_rst_n stays 1. Then IDLE.
- Counters:
  - Bit counter is 6-bit.
  - Word counter is LEN_W bits and compares against the latched cmd_len; no wrap.
  - cmd_len=0xFFFF transfers 65535 words.
- Command acceptance: cmd_valid while busy is ignored (cmd_ready=0); the command is not queued.
- Reset mid-operation: rst at any state returns all outputs to reset values on the next edge. Partial read words are discarded and no rdata_valid or done is produced.

Test Plan:
- Write, cmd_len=4, addr=0:
  - wdata 0x00012117, 0x04010113, 0x00022517, 0x03c50513 always valid.
  - Expect chain_rst_n low 10 cycles, then 64 header bits: bit0=1, count=4, addr=0.
  - Expect 128 data bits LSB first, wdata_ready pulse every 32 cycles, done at cycle 10+64+128+1.
- Read, cmd_len=2, addr=0x10; behavioural wrapper model returns 0xDEADBEEF, 0x12345678 at READ_LAT=1.
  - Expect rdata_valid twice with those values, then done.
- cmd_len=0 write:
  - Expect header only, with count field 0.
  - Expect done 75 cycles after accept and no wdata_ready.
- Underrun: drop wdata_valid before word 2.
  - Expect err_underrun=1 and chain_rst_n low the next cycle.
  - Expect no done, and IDLE with cmd_ready=1.
- Assert rst during RDATA bit 17:
  - Expect outputs at reset values next cycle and no rdata_valid.
  - A following command completes normally and clears err_underrun.
- cmd_valid held during a transfer: expect exactly one transaction per handshake and cmd_ready=0 while busy.
